// File: rtl/sr_latch_bank_ctrl.sv
// Round-robin command sequencer for a bank of clocked SR latches.
// Optional readback check enabled by SR_LATCH_CTRL_READBACK_EN.
module sr_latch_bank_ctrl #(
    parameter  int NUM_LATCH = 8,
    parameter  int PULSE_CYC = 2,
    localparam int IDX_W     = $clog2(NUM_LATCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    input  logic [3:0]           req_op,
    input  logic [2*IDX_W-1:0]   req_idx,
    output logic [1:0]           req_ready,
    output logic [NUM_LATCH-1:0] latch_s,
    output logic [NUM_LATCH-1:0] latch_r,
    input  logic [NUM_LATCH-1:0] latch_q,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 err_clr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_CLR = 2'd1;
    localparam logic [1:0] OP_TGL = 2'd2;
    localparam logic [1:0] OP_ALL = 2'd3;

    localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYC - 1);

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic                 last_gnt;
    logic [1:0]           gnt;
    logic [1:0]           sel_op;
    logic [1:0]           res_op;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_LATCH-1:0] onehot;
    logic [NUM_LATCH-1:0] s_nxt;
    logic [NUM_LATCH-1:0] r_nxt;
    logic                 xfer;
    logic                 oor;
    logic                 rb_fail;
    logic                 err_set;

    // Grant one requester in IDLE; on contention favour the one not served last
    always_comb begin
        gnt = 2'b00;
        if (state == S_IDLE && rst_n) begin
            case (req_valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign busy      = (state == S_DRIVE) || (state == S_SETTLE);

    // Decode the granted command into the s/r pattern held during DRIVE
    always_comb begin
        sel_op  = gnt[1] ? req_op[3:2] : req_op[1:0];
        sel_idx = gnt[1] ? req_idx[2*IDX_W-1:IDX_W] : req_idx[IDX_W-1:0];
        onehot  = NUM_LATCH'(1) << sel_idx;
        res_op  = sel_op;
        if (sel_op == OP_TGL)
            res_op = (|(latch_q & onehot)) ? OP_CLR : OP_SET;
        s_nxt = (res_op == OP_SET) ? onehot : '0;
        r_nxt = '0;
        if (res_op == OP_ALL)
            r_nxt = '1;
        else if (res_op == OP_CLR)
            r_nxt = onehot;
        oor = (res_op != OP_ALL) && !(|onehot);
    end

`ifdef SR_LATCH_CTRL_READBACK_EN
    logic [NUM_LATCH-1:0] exp_mask;
    logic [NUM_LATCH-1:0] exp_val;

    // Remember which bits should read back, and their values, after the pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_mask <= '0;
            exp_val  <= '0;
        end else if (xfer) begin
            exp_mask <= (res_op == OP_ALL) ? '1 : onehot;
            exp_val  <= s_nxt;
        end
    end

    assign rb_fail = (state == S_SETTLE) &&
                     (|((latch_q ^ exp_val) & exp_mask));
`else
    assign rb_fail = 1'b0;
`endif

    assign err_set = (xfer && oor) || rb_fail;

    // Sequencer: accept, hold the pulse PULSE_CYC cycles, settle one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            latch_s  <= '0;
            latch_r  <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        state    <= S_DRIVE;
                        cnt      <= '0;
                        last_gnt <= gnt[1];
                        latch_s  <= s_nxt;
                        latch_r  <= r_nxt;
                    end
                end
                S_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        state   <= S_SETTLE;
                        latch_s <= '0;
                        latch_r <= '0;
                        done    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    latch_s <= '0;
                    latch_r <= '0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag; a new error outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (err_set)
            err <= 1'b1;
        else if (err_clr)
            err <= 1'b0;
    end

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Directed bench for sr_latch_bank_ctrl with a behavioural SR latch bank.
// A second instance with NUM_LATCH=9 exercises out-of-range indices.
module tb_sr_latch_bank_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] req_op;
    logic [5:0] req_idx;
    logic [1:0] req_ready;
    logic [7:0] latch_s;
    logic [7:0] latch_r;
    logic [7:0] latch_q;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_clr;

    logic [1:0] req_valid2;
    logic [3:0] req_op2;
    logic [7:0] req_idx2;
    logic [1:0] req_ready2;
    logic [8:0] latch_s2;
    logic [8:0] latch_r2;
    logic [8:0] q9;
    logic       busy2;
    logic       done2;
    logic       err2;
    logic       err_clr2;

    logic [7:0] q8;
    logic       load;
    logic [7:0] load_val;
    logic       force_zero;
    logic       exp_rb_err;

    int n_checks = 0;
    int n_fail   = 0;

    sr_latch_bank_ctrl #(.NUM_LATCH(8), .PULSE_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
        .req_ready(req_ready),
        .latch_s(latch_s), .latch_r(latch_r), .latch_q(latch_q),
        .busy(busy), .done(done), .err(err), .err_clr(err_clr)
    );

    sr_latch_bank_ctrl #(.NUM_LATCH(9), .PULSE_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_op(req_op2), .req_idx(req_idx2),
        .req_ready(req_ready2),
        .latch_s(latch_s2), .latch_r(latch_r2), .latch_q(q9),
        .busy(busy2), .done(done2), .err(err2), .err_clr(err_clr2)
    );

    // Clocked SR latch bank models
    always @(posedge clk) begin
        if (load) begin
            q8 <= load_val;
            q9 <= 9'h000;
        end else begin
            q8 <= (q8 & ~latch_r) | latch_s;
            q9 <= (q9 & ~latch_r2) | latch_s2;
        end
    end

    assign latch_q = force_zero ? 8'h00 : q8;

    // Bank-wide invariant on every cycle
    always @(negedge clk) begin
        n_checks++;
        if ((latch_s & latch_r) !== 8'h00 ||
            (!busy && (latch_s | latch_r) !== 8'h00)) begin
            n_fail++;
            $display("FAIL sr_invariant: s=%h r=%h busy=%b, required no overlap and idle quiet",
                     latch_s, latch_r, busy);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        load = 1'b1;
        load_val = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_q(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 00", req_ready);
        end
        n_checks++;
        if (latch_s !== 8'h00 || latch_r !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sr: got s=%h r=%h expected 00/00", latch_s, latch_r);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b done=%b err=%b err2=%b expected 0",
                     busy, done, err, err2);
        end
        req_valid = 2'b00;
        rst_n = 1'b1;
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_set();
        req_valid = 2'b01;
        req_op = 4'b0000;
        req_idx = 6'd3;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL set_ready: got %b expected 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        for (int t = 1; t <= 2; t++) begin
            n_checks++;
            if (latch_s !== 8'h08 || latch_r !== 8'h00 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL set_pulse_T%0d: got s=%h r=%h busy=%b expected 08/00/1",
                         t, latch_s, latch_r, busy);
            end
            @(negedge clk);
        end
        n_checks++;
        if (latch_s !== 8'h00 || done !== 1'b1 || latch_q[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL set_settle: got s=%h done=%b q3=%b expected 00/1/1",
                     latch_s, done, latch_q[3]);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL set_idle: got done=%b err=%b busy=%b expected 0/0/0",
                     done, err, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        logic [7:0] exp_s;
        logic [7:0] exp_r;
        int g;
        do_reset();
        req_valid = 2'b11;
        req_op = 4'b0001;
        req_idx = {3'd5, 3'd1};
        for (int k = 0; k < 16; k++) begin
            g = (k / 4) % 2;
            exp_rdy = (k % 4 == 0) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_checks++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_ready_c%0d: got %b expected %b", k, req_ready, exp_rdy);
            end
            if (k % 4 == 1 || k % 4 == 2) begin
                exp_s = (g == 1) ? 8'h20 : 8'h00;
                exp_r = (g == 0) ? 8'h02 : 8'h00;
                n_checks++;
                if (latch_s !== exp_s || latch_r !== exp_r) begin
                    n_fail++;
                    $display("FAIL b2b_pulse_c%0d: got s=%h r=%h expected %h/%h",
                             k, latch_s, latch_r, exp_s, exp_r);
                end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        n_checks++;
        if (latch_q !== 8'h20) begin
            n_fail++;
            $display("FAIL b2b_q: got %h expected 20", latch_q);
        end
        @(negedge clk);
    endtask

    task automatic test_toggle();
        logic [7:0] exp_s;
        logic [7:0] exp_r;
        load_q(8'h04);
        for (int n = 0; n < 2; n++) begin
            exp_s = (n == 1) ? 8'h04 : 8'h00;
            exp_r = (n == 0) ? 8'h04 : 8'h00;
            req_valid = 2'b01;
            req_op = 4'b0010;
            req_idx = 6'd2;
            @(negedge clk);
            req_valid = 2'b00;
            for (int t = 1; t <= 2; t++) begin
                n_checks++;
                if (latch_s !== exp_s || latch_r !== exp_r) begin
                    n_fail++;
                    $display("FAIL toggle%0d_T%0d: got s=%h r=%h expected %h/%h",
                             n, t, latch_s, latch_r, exp_s, exp_r);
                end
                @(negedge clk);
            end
            n_checks++;
            if (done !== 1'b1 || latch_q[2] !== logic'(n)) begin
                n_fail++;
                $display("FAIL toggle%0d_settle: got done=%b q2=%b expected 1/%0d",
                         n, done, latch_q[2], n);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clear_all();
        load_q(8'hFF);
        req_valid = 2'b01;
        req_op = 4'b0011;
        req_idx = 6'd0;
        @(negedge clk);
        req_valid = 2'b00;
        for (int t = 1; t <= 2; t++) begin
            n_checks++;
            if (latch_r !== 8'hFF || latch_s !== 8'h00) begin
                n_fail++;
                $display("FAIL clrall_T%0d: got s=%h r=%h expected 00/ff",
                         t, latch_s, latch_r);
            end
            @(negedge clk);
        end
        n_checks++;
        if (latch_q !== 8'h00 || done !== 1'b1 || latch_r !== 8'h00) begin
            n_fail++;
            $display("FAIL clrall_settle: got q=%h done=%b r=%h expected 00/1/00",
                     latch_q, done, latch_r);
        end
        @(negedge clk);
    endtask

    task automatic test_error();
        req_valid2 = 2'b01;
        req_op2 = 4'b0000;
        req_idx2 = 8'd8;
        @(negedge clk);
        req_valid2 = 2'b00;
        n_checks++;
        if (latch_s2 !== 9'h100 || err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_idx8: got s=%h err=%b expected 100/0", latch_s2, err2);
        end
        repeat (3) @(negedge clk);
        req_valid2 = 2'b01;
        req_idx2 = 8'd9;
        @(negedge clk);
        req_valid2 = 2'b00;
        for (int t = 1; t <= 2; t++) begin
            n_checks++;
            if (latch_s2 !== 9'h000 || latch_r2 !== 9'h000 ||
                busy2 !== 1'b1 || err2 !== 1'b1) begin
                n_fail++;
                $display("FAIL err_oor_T%0d: got s=%h r=%h busy=%b err=%b expected 0/0/1/1",
                         t, latch_s2, latch_r2, busy2, err2);
            end
            @(negedge clk);
        end
        n_checks++;
        if (done2 !== 1'b1) begin
            n_fail++;
            $display("FAIL err_oor_done: got %b expected 1", done2);
        end
        @(negedge clk);
        n_checks++;
        if (err2 !== 1'b1 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b busy=%b expected 1/0", err2, busy2);
        end
        err_clr2 = 1'b1;
        @(negedge clk);
        err_clr2 = 1'b0;
        n_checks++;
        if (err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr: got %b expected 0", err2);
        end
    endtask

    task automatic test_readback();
`ifdef SR_LATCH_CTRL_READBACK_EN
        exp_rb_err = 1'b1;
`else
        exp_rb_err = 1'b0;
`endif
        force_zero = 1'b1;
        req_valid = 2'b01;
        req_op = 4'b0000;
        req_idx = 6'd4;
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++;
        if (latch_s !== 8'h10) begin
            n_fail++;
            $display("FAIL rb_pulse: got s=%h expected 10", latch_s);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rb_done: got %b expected 1", done);
        end
        @(negedge clk);
        n_checks++;
        if (err !== exp_rb_err) begin
            n_fail++;
            $display("FAIL rb_err: got %b expected %b", err, exp_rb_err);
        end
        force_zero = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_err_clr: got %b expected 0", err);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b01;
        req_op = 4'b0000;
        req_idx = 6'd0;
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++;
        if (latch_s !== 8'h01) begin
            n_fail++;
            $display("FAIL mid_pulse: got s=%h expected 01", latch_s);
        end
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (latch_s !== 8'h00 || busy !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_async: got s=%h busy=%b rdy=%b expected 00/0/00",
                     latch_s, busy, req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_nodone: got %b expected 0", done);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_regrant: got rdy=%b err=%b expected 01/0", req_ready, err);
        end
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_op = 4'b0000;
        req_idx = 6'd0;
        err_clr = 1'b0;
        req_valid2 = 2'b00;
        req_op2 = 4'b0000;
        req_idx2 = 8'd0;
        err_clr2 = 1'b0;
        load = 1'b1;
        load_val = 8'h00;
        force_zero = 1'b0;
        exp_rb_err = 1'b0;
        test_reset();
        test_set();
        test_back_to_back();
        test_toggle();
        test_clear_all();
        test_error();
        test_readback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
